shift_seq_ctrl: RTL and testbench
=================================

// Module: shift_seq_ctrl
// PURPOSE
//   Sequencer for one shift_reg instance used as a parallel-to-serial converter.
//   Accepts a word over a valid/ready handshake, loads it into the shift register,
//   then issues N-1 shifts paced by a programmable bit period.
//   Presents the active end bit as o_serial and pulses o_done at the end.
//   Sits between a word producer (CPU/FIFO) and any bit-serial output (UART/SPI TX-style).
// PARAMETERS
//   N      8  shift register width, bits per transaction (N >= 2)
//   DIV_W  8  width of bit-period field
// PORTS
//   i_clk             in   1      clock; all logic on rising edge
//   i_reset           in   1      asynchronous, active-high reset
//   i_valid           in   1      request: word and config valid
//   o_ready           out  1      controller idle, request accepted when i_valid&o_ready
//   i_data            in   N      word to serialise
//   i_lsb_first       in   1      1: shift right, emit bit 0 first; 0: shift left, emit bit N-1 first
//   i_period          in   DIV_W  extra hold cycles per bit (P)
//   i_abort           in   1      cancel in-flight transaction
//   o_sr_ce           out  1      shift_reg clock enable
//   o_sr_reset        out  1      shift_reg synchronous clear
//   o_sr_we           out  1      shift_reg parallel load
//   o_sr_shift_left   out  1      shift_reg shift left
//   o_sr_shift_right  out  1      shift_reg shift right
//   o_sr_data         out  N      shift_reg load data
//   i_sr_q            in   N      shift_reg contents
//   o_serial          out  1      current serial bit
//   o_busy            out  1      transaction in flight (state != IDLE)
//   o_done            out  1      one-cycle pulse: last bit completed
// BEHAVIOUR
//   States: IDLE, LOAD, HOLD, SHIFT, DONE, CLEAR. Reset -> IDLE.
//   All outputs are decoded from registered state, so during/after reset:
//     o_ready=1; all o_sr_* strobes=0; o_busy=0; o_done=0; o_serial=0.
//   Resettable registers: state, divider, bit counter, captured word/dir/period (all 0).
//   IDLE: o_ready=1. On i_valid: capture i_data, i_lsb_first, i_period -> LOAD. i_abort ignored.
//   LOAD (1 cycle): o_sr_ce=1, o_sr_we=1, o_sr_data=captured word; bit_cnt<=0, div<=P -> HOLD.
//   HOLD: div counts down 1/cycle; at div==0: bit_cnt==N-1 -> DONE, else -> SHIFT.
//   SHIFT (1 cycle): o_sr_ce=1 + o_sr_shift_right (lsb_first) or o_sr_shift_left; bit_cnt++, div<=P -> HOLD.
//   DONE (1 cycle): o_done=1 -> IDLE.
//   At most one of we/shift_left/shift_right/reset is high in any cycle, and only with o_sr_ce=1.
//   o_sr_data = captured word in all states; only sampled when o_sr_we=1.
//   o_serial = lsb_first ? i_sr_q[0] : i_sr_q[N-1] in HOLD/SHIFT/DONE; 0 in IDLE/LOAD/CLEAR.
//   Timing (handshake edge = cycle 0): LOAD in cycle 1; bit k on o_serial during cycles
//     2+k*(P+2) .. 3+k*(P+2)+P (P+2 cycles per bit, every bit incl. last);
//     o_done in cycle 1+N*(P+2); o_ready=1 from cycle 2+N*(P+2).
//   P=0: 2 cycles per bit. P=2^DIV_W-1: no overflow, div is DIV_W wide.
//   Config inputs are sampled only at the handshake; changes mid-transaction have no effect.
//   i_abort in LOAD/HOLD/SHIFT/DONE: next state CLEAR (no o_done; abort in DONE suppresses nothing already
//     pulsed). CLEAR (1 cycle): o_sr_ce=1, o_sr_reset=1 -> IDLE.
//   Async reset mid-transaction: immediate IDLE, no strobes; shift_reg contents not cleared
//     (o_serial masked to 0).
//   Back-to-back: new request can be accepted in the first IDLE cycle after DONE/CLEAR.
// TESTING
//   T1 N=8, P=0, msb-first, i_data=8'hA5 -> o_serial 1,0,1,0,0,1,0,1, 2 cycles each; o_done at cycle 17.
//   T2 P=3, lsb-first, i_data=8'h01 -> o_serial 1 for cycles 2..6, then 0; 7 shift_right strobes; o_done at cycle 41.
//   T3 i_abort asserted cycle 5 of T1 -> CLEAR in cycle 6 (o_sr_ce=o_sr_reset=1), o_done never pulses, o_ready=1 at cycle 7.
//   T4 i_reset pulsed mid-HOLD -> outputs immediately idle values, o_ready=1; new request then completes normally.
//   T5 i_valid held high continuously, two words 8'hFF then 8'h00 -> second accepted cycle 18, no gap bits lost, one o_done each.
//   T6 every cycle of T1-T5: assert one-hot of {we,shift_left,shift_right,reset} under o_sr_ce; o_busy==!o_ready.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// Sequencer that drives an external shift_reg as a parallel-to-serial converter.
// It loads a word, then paces N-1 shifts by a programmable bit period and pulses o_done at the end.
module shift_seq_ctrl #(
  parameter int N     = 8,
  parameter int DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [N-1:0]     i_data,
  input  logic             i_lsb_first,
  input  logic [DIV_W-1:0] i_period,
  input  logic             i_abort,
  output logic             o_sr_ce,
  output logic             o_sr_reset,
  output logic             o_sr_we,
  output logic             o_sr_shift_left,
  output logic             o_sr_shift_right,
  output logic [N-1:0]     o_sr_data,
  input  logic [N-1:0]     i_sr_q,
  output logic             o_serial,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CNT_W = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_HOLD  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4,
    S_CLEAR = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_word;
  logic             r_lsb;
  logic [DIV_W-1:0] r_period;
  logic             w_end_bit;
  logic             w_unused_sr;

  // Only the two end bits of the shift register are observed.
  assign w_unused_sr = ^i_sr_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_valid) w_next = S_LOAD;
        else         w_next = S_IDLE;
      end
      S_LOAD: begin
        if (i_abort) w_next = S_CLEAR;
        else         w_next = S_HOLD;
      end
      S_HOLD: begin
        if (i_abort)                        w_next = S_CLEAR;
        else if (r_div != {DIV_W{1'b0}})    w_next = S_HOLD;
        else if (r_cnt == CNT_W'(N - 1))    w_next = S_DONE;
        else                                w_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (i_abort) w_next = S_CLEAR;
        else         w_next = S_HOLD;
      end
      S_DONE: begin
        if (i_abort) w_next = S_CLEAR;
        else         w_next = S_IDLE;
      end
      S_CLEAR: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Config is captured only at the handshake so mid-transaction input changes are ignored.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_div    <= {DIV_W{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_word   <= {N{1'b0}};
      r_lsb    <= 1'b0;
      r_period <= {DIV_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_word   <= i_data;
            r_lsb    <= i_lsb_first;
            r_period <= i_period;
          end
        end
        S_LOAD: begin
          r_cnt <= {CNT_W{1'b0}};
          r_div <= r_period;
        end
        S_HOLD: begin
          if (r_div != {DIV_W{1'b0}}) r_div <= r_div - DIV_W'(1);
        end
        S_SHIFT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_div <= r_period;
        end
        default: begin
          r_div <= r_div;
        end
      endcase
    end
  end

  assign w_end_bit = r_lsb ? i_sr_q[0] : i_sr_q[N-1];

  // Every output is a pure decode of the registered state and captured config.
  always_comb begin
    o_ready          = (r_state == S_IDLE);
    o_busy           = (r_state != S_IDLE);
    o_sr_we          = (r_state == S_LOAD);
    o_sr_shift_right = (r_state == S_SHIFT) &&  r_lsb;
    o_sr_shift_left  = (r_state == S_SHIFT) && !r_lsb;
    o_sr_reset       = (r_state == S_CLEAR);
    o_sr_ce          = (r_state == S_LOAD) || (r_state == S_SHIFT) || (r_state == S_CLEAR);
    o_done           = (r_state == S_DONE);
    o_sr_data        = r_word;
    if ((r_state == S_HOLD) || (r_state == S_SHIFT) || (r_state == S_DONE)) begin
      o_serial = w_end_bit;
    end else begin
      o_serial = 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural shift_reg model on its strobe outputs.
module tb_shift_seq_ctrl;

  localparam int N     = 8;
  localparam int DIV_W = 8;

  logic             i_clk = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [N-1:0]     i_data = 8'h00;
  logic             i_lsb_first = 1'b0;
  logic [DIV_W-1:0] i_period = 8'd0;
  logic             i_abort = 1'b0;
  logic             o_sr_ce, o_sr_reset, o_sr_we, o_sr_shift_left, o_sr_shift_right;
  logic [N-1:0]     o_sr_data;
  logic [N-1:0]     sr_q = 8'h00;
  logic             o_serial, o_busy, o_done;

  int checks = 0;
  int failures = 0;

  shift_seq_ctrl #(.N(N), .DIV_W(DIV_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_lsb_first(i_lsb_first), .i_period(i_period), .i_abort(i_abort),
    .o_sr_ce(o_sr_ce), .o_sr_reset(o_sr_reset), .o_sr_we(o_sr_we),
    .o_sr_shift_left(o_sr_shift_left), .o_sr_shift_right(o_sr_shift_right),
    .o_sr_data(o_sr_data), .i_sr_q(sr_q), .o_serial(o_serial), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  // External shift register; not touched by i_reset.
  always @(posedge i_clk) begin
    if (o_sr_ce) begin
      if (o_sr_reset)            sr_q <= 8'h00;
      else if (o_sr_we)          sr_q <= o_sr_data;
      else if (o_sr_shift_left)  sr_q <= {sr_q[N-2:0], 1'b0};
      else if (o_sr_shift_right) sr_q <= {1'b0, sr_q[N-1:1]};
    end
  end

  // Strobe exclusivity and busy/ready complement, every cycle out of reset.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      checks++;
      if (o_sr_ce ? !$onehot({o_sr_we, o_sr_shift_left, o_sr_shift_right, o_sr_reset})
                  : ({o_sr_we, o_sr_shift_left, o_sr_shift_right, o_sr_reset} != 4'b0000)) begin
        failures++;
        $display("FAIL strobe_onehot t=%0t ce=%b we/shl/shr/rst=%b%b%b%b", $time, o_sr_ce,
                 o_sr_we, o_sr_shift_left, o_sr_shift_right, o_sr_reset);
      end
      checks++;
      if (o_busy !== !o_ready) begin
        failures++;
        $display("FAIL busy_ready t=%0t busy=%b ready=%b required busy=!ready", $time, o_busy, o_ready);
      end
    end
  end

  // Expected serial bit at cycle c of a transaction whose handshake is cycle 0.
  function automatic logic exp_ser(input logic [7:0] d, input logic lsb, input int p, input int c);
    int k;
    if (c < 2 || c > 1 + N * (p + 2)) return 1'b0;
    k = (c - 2) / (p + 2);
    return lsb ? d[k] : d[N-1-k];
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    step();
    step();
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_status ready=%b busy=%b done=%b required 1,0,0", o_ready, o_busy, o_done);
    end
    checks++;
    if ({o_sr_ce, o_sr_we, o_sr_shift_left, o_sr_shift_right, o_sr_reset} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_strobes got=%b required 00000",
               {o_sr_ce, o_sr_we, o_sr_shift_left, o_sr_shift_right, o_sr_reset});
    end
    checks++;
    if (o_serial !== 1'b0 || o_sr_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data serial=%b sr_data=%h required 0,00", o_serial, o_sr_data);
    end
    i_reset = 1'b0;
    step();
  endtask

  // T1: A5 msb-first, P=0, config inputs scrambled after the handshake.
  task automatic test_msb_first();
    i_data = 8'hA5; i_lsb_first = 1'b0; i_period = 8'd0; i_valid = 1'b1;
    for (int c = 0; c <= 18; c++) begin
      if (c == 1) begin
        i_valid = 1'b0; i_data = 8'h00; i_lsb_first = 1'b1; i_period = 8'd5;
      end
      checks++;
      if (o_serial !== exp_ser(8'hA5, 1'b0, 0, c)) begin
        failures++;
        $display("FAIL t1_serial cyc=%0d got=%b required=%b", c, o_serial, exp_ser(8'hA5, 1'b0, 0, c));
      end
      checks++;
      if (o_done !== (c == 17)) begin
        failures++;
        $display("FAIL t1_done cyc=%0d got=%b required=%b", c, o_done, (c == 17));
      end
      checks++;
      if (o_ready !== (c == 0 || c >= 18)) begin
        failures++;
        $display("FAIL t1_ready cyc=%0d got=%b required=%b", c, o_ready, (c == 0 || c >= 18));
      end
      if (c == 1) begin
        checks++;
        if (o_sr_we !== 1'b1 || o_sr_ce !== 1'b1 || o_sr_data !== 8'hA5) begin
          failures++;
          $display("FAIL t1_load we=%b ce=%b data=%h required 1,1,a5", o_sr_we, o_sr_ce, o_sr_data);
        end
      end
      step();
    end
  endtask

  // T2: 01 lsb-first, P=3; exactly seven right shifts.
  task automatic test_lsb_first();
    int nshr = 0;
    int nshl = 0;
    i_data = 8'h01; i_lsb_first = 1'b1; i_period = 8'd3; i_valid = 1'b1;
    for (int c = 0; c <= 42; c++) begin
      if (c == 1) i_valid = 1'b0;
      if (o_sr_shift_right) nshr++;
      if (o_sr_shift_left) nshl++;
      checks++;
      if (o_serial !== exp_ser(8'h01, 1'b1, 3, c)) begin
        failures++;
        $display("FAIL t2_serial cyc=%0d got=%b required=%b", c, o_serial, exp_ser(8'h01, 1'b1, 3, c));
      end
      checks++;
      if (o_done !== (c == 41)) begin
        failures++;
        $display("FAIL t2_done cyc=%0d got=%b required=%b", c, o_done, (c == 41));
      end
      checks++;
      if (o_ready !== (c == 0 || c >= 42)) begin
        failures++;
        $display("FAIL t2_ready cyc=%0d got=%b required=%b", c, o_ready, (c == 0 || c >= 42));
      end
      step();
    end
    checks++;
    if (nshr != 7 || nshl != 0) begin
      failures++;
      $display("FAIL t2_shift_count shr=%0d shl=%0d required 7,0", nshr, nshl);
    end
  endtask

  // T3: abort in cycle 5 of T1, then abort held in IDLE alongside a request.
  task automatic test_abort();
    int waited = 0;
    i_data = 8'hA5; i_lsb_first = 1'b0; i_period = 8'd0; i_valid = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      if (c == 1) i_valid = 1'b0;
      if (c == 5) i_abort = 1'b1;
      if (c == 6) i_abort = 1'b0;
      checks++;
      if (o_done !== 1'b0) begin
        failures++;
        $display("FAIL t3_no_done cyc=%0d got=%b required=0", c, o_done);
      end
      if (c <= 5) begin
        checks++;
        if (o_serial !== exp_ser(8'hA5, 1'b0, 0, c)) begin
          failures++;
          $display("FAIL t3_serial cyc=%0d got=%b required=%b", c, o_serial, exp_ser(8'hA5, 1'b0, 0, c));
        end
      end
      if (c == 6) begin
        checks++;
        if (o_sr_ce !== 1'b1 || o_sr_reset !== 1'b1 || o_serial !== 1'b0 || o_busy !== 1'b1) begin
          failures++;
          $display("FAIL t3_clear ce=%b rst=%b serial=%b busy=%b required 1,1,0,1",
                   o_sr_ce, o_sr_reset, o_serial, o_busy);
        end
      end
      if (c >= 7) begin
        checks++;
        if (o_ready !== 1'b1) begin
          failures++;
          $display("FAIL t3_ready cyc=%0d got=%b required=1", c, o_ready);
        end
      end
      if (c == 7) begin
        checks++;
        if (sr_q !== 8'h00) begin
          failures++;
          $display("FAIL t3_sr_cleared got=%h required=00", sr_q);
        end
      end
      step();
    end
    i_data = 8'h3C; i_valid = 1'b1; i_abort = 1'b1;
    step();
    i_valid = 1'b0; i_abort = 1'b0;
    checks++;
    if (o_sr_we !== 1'b1 || o_sr_data !== 8'h3C) begin
      failures++;
      $display("FAIL t3_idle_abort_ignored we=%b data=%h required 1,3c", o_sr_we, o_sr_data);
    end
    while (!o_ready && waited < 40) begin
      step();
      waited++;
    end
    checks++;
    if (waited != 17) begin
      failures++;
      $display("FAIL t3_idle_abort_len cycles=%0d required=17", waited);
    end
  endtask

  // T4: async reset mid-HOLD, then a fresh lsb-first request with P=1.
  task automatic test_reset_mid();
    i_data = 8'hC3; i_lsb_first = 1'b0; i_period = 8'd2; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    step();
    step();
    #2 i_reset = 1'b1;
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_serial !== 1'b0 || o_done !== 1'b0 ||
        {o_sr_ce, o_sr_we, o_sr_shift_left, o_sr_shift_right, o_sr_reset} !== 5'b00000) begin
      failures++;
      $display("FAIL t4_async_idle ready=%b busy=%b serial=%b done=%b ce=%b required 1,0,0,0,0",
               o_ready, o_busy, o_serial, o_done, o_sr_ce);
    end
    step();
    i_reset = 1'b0;
    step();
    i_data = 8'h3C; i_lsb_first = 1'b1; i_period = 8'd1; i_valid = 1'b1;
    for (int c = 0; c <= 26; c++) begin
      if (c == 1) i_valid = 1'b0;
      checks++;
      if (o_serial !== exp_ser(8'h3C, 1'b1, 1, c)) begin
        failures++;
        $display("FAIL t4_serial cyc=%0d got=%b required=%b", c, o_serial, exp_ser(8'h3C, 1'b1, 1, c));
      end
      checks++;
      if (o_done !== (c == 25) || o_ready !== (c == 0 || c >= 26)) begin
        failures++;
        $display("FAIL t4_done_ready cyc=%0d done=%b ready=%b required %b,%b", c, o_done, o_ready,
                 (c == 25), (c == 0 || c >= 26));
      end
      step();
    end
  endtask

  // T5: i_valid held high across two words FF then 00.
  task automatic test_back_to_back();
    int ndone = 0;
    i_data = 8'hFF; i_lsb_first = 1'b0; i_period = 8'd0; i_valid = 1'b1;
    for (int c = 0; c <= 37; c++) begin
      if (c == 1) i_data = 8'h00;
      if (c == 19) i_valid = 1'b0;
      if (o_done) ndone++;
      checks++;
      if (o_serial !== (c >= 2 && c <= 17)) begin
        failures++;
        $display("FAIL t5_serial cyc=%0d got=%b required=%b", c, o_serial, (c >= 2 && c <= 17));
      end
      checks++;
      if (o_ready !== (c == 0 || c == 18 || c >= 36)) begin
        failures++;
        $display("FAIL t5_ready cyc=%0d got=%b required=%b", c, o_ready, (c == 0 || c == 18 || c >= 36));
      end
      checks++;
      if (o_done !== (c == 17 || c == 35)) begin
        failures++;
        $display("FAIL t5_done cyc=%0d got=%b required=%b", c, o_done, (c == 17 || c == 35));
      end
      if (c == 19) begin
        checks++;
        if (o_sr_we !== 1'b1 || o_sr_data !== 8'h00) begin
          failures++;
          $display("FAIL t5_second_load we=%b data=%h required 1,00", o_sr_we, o_sr_data);
        end
      end
      step();
    end
    checks++;
    if (ndone != 2) begin
      failures++;
      $display("FAIL t5_done_count got=%0d required=2", ndone);
    end
  endtask

  // Largest period: 257 cycles per bit with an 8-bit divider.
  task automatic test_max_period();
    i_data = 8'h81; i_lsb_first = 1'b1; i_period = 8'hFF; i_valid = 1'b1;
    for (int c = 0; c <= 2058; c++) begin
      if (c == 1) i_valid = 1'b0;
      checks++;
      if (o_serial !== exp_ser(8'h81, 1'b1, 255, c) || o_done !== (c == 2057) ||
          o_ready !== (c == 0 || c >= 2058)) begin
        failures++;
        $display("FAIL tmax cyc=%0d serial=%b done=%b ready=%b required %b,%b,%b", c, o_serial, o_done,
                 o_ready, exp_ser(8'h81, 1'b1, 255, c), (c == 2057), (c == 0 || c >= 2058));
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_max_period();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
